cache_ctrl_fsm: RTL and testbench

- Sequential, parametrised controller for the direct-mapped, write-through, no-write-allocate data cache between the MIPS pipeline and main memory.
- Replaces the combinational data-memory controller; adds:
  - multi-cycle memory handshake (mem_ready) and pipeline stall generation;
  - configurable block size and data width;
  - selectable write-hit policy (invalidate or update);
  - hit/miss performance counters.
- Tag/data arrays and the tag compare stay outside; this block consumes `hit` and drives array strobes.

---
 rtl/cache_ctrl_pkg.sv | 17 +
 rtl/cache_word_select.sv | 28 ++
 rtl/cache_ctrl_fsm.sv | 161 ++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared definitions for the data-cache controller: the FSM state encoding and
// the two write-hit policy codes selected by the WR_HIT_UPDATE parameter.
// -----------------------------------------------------------------------------
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WR_MEM = 2'd2
  } state_e;

  localparam bit WR_HIT_INVALIDATE = 1'b0;
  localparam bit WR_HIT_UPDATE     = 1'b1;

endpackage : cache_ctrl_pkg

// File: rtl/cache_word_select.sv
// -----------------------------------------------------------------------------
// cache_word_select
// Picks one DATA_W word out of a WORDS-word refill block.
// Ports:
//   block_i  - packed block, word i at bits [DATA_W*(i+1)-1 : DATA_W*i]
//   sel_i    - word index within the block
//   word_o   - selected word
// -----------------------------------------------------------------------------
module cache_word_select #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int OFF_W  = $clog2(WORDS)
) (
  input  logic [DATA_W*WORDS-1:0] block_i,
  input  logic [OFF_W-1:0]        sel_i,
  output logic [DATA_W-1:0]       word_o
);

  // NOTE: assigning a default before the loop keeps every path driven, so no
  // latch is inferred when sel_i matches none of the loop indices.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (sel_i == OFF_W'(i)) word_o = block_i[i*DATA_W +: DATA_W];
    end
  end

endmodule : cache_word_select

// File: rtl/cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm
// Controller for a direct-mapped, write-through, no-write-allocate data cache.
// Loads that hit complete with zero added latency; misses refill a whole block
// from memory; stores always go through to memory and either invalidate or
// update the cached word on a hit.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cpu_read/cpu_write  - CPU load/store requests (held while stall=1)
//   word_offset         - word index within the block
//   cpu_wdata           - store data
//   hit                 - tag match and valid, from the external tag compare
//   word_from_cache     - word read from the data array
//   block_from_mem      - refill block from memory
//   mem_ready           - memory completes the current transfer this cycle
//   mem_read/mem_write  - memory block-read / word-write requests
//   mem_wdata           - registered store data
//   cache_read          - data-array read enable
//   cache_write         - whole-block refill into data/tag arrays
//   cache_word_write    - single-word update on write hit (update policy)
//   invalid             - clear valid bit on write hit (invalidate policy)
//   stall               - freeze the pipeline
//   data_out            - load result
//   hit_count/miss_count- accepted read hits / misses, wrapping
// -----------------------------------------------------------------------------
module cache_ctrl_fsm #(
  parameter int DATA_W        = 32,
  parameter int WORDS         = 4,
  parameter int OFF_W         = $clog2(WORDS),
  parameter bit WR_HIT_UPDATE = 1'b0,
  parameter int CNT_W         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [OFF_W-1:0]        word_offset,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    hit,
  input  logic [DATA_W-1:0]       word_from_cache,
  input  logic [DATA_W*WORDS-1:0] block_from_mem,
  input  logic                    mem_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    cache_read,
  output logic                    cache_write,
  output logic                    cache_word_write,
  output logic                    invalid,
  output logic                    stall,
  output logic [DATA_W-1:0]       data_out,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);

  import cache_ctrl_pkg::*;

  localparam bit UpdateOnHit = (WR_HIT_UPDATE == cache_ctrl_pkg::WR_HIT_UPDATE);

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [DATA_W-1:0]  refill_word;

  cache_word_select #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .OFF_W  (OFF_W)
  ) u_word_select (
    .block_i (block_from_mem),
    .sel_i   (off_q),
    .word_o  (refill_word)
  );

  // Strobes are Mealy outputs: a read hit and a write-hit invalidate/update
  // must act in the same cycle the request is seen, and the refill completes
  // in the mem_ready cycle itself.
  always_comb begin
    state_d          = state_q;
    off_d            = off_q;
    wdata_d          = wdata_q;
    hit_cnt_d        = hit_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    cache_read       = 1'b0;
    cache_write      = 1'b0;
    cache_word_write = 1'b0;
    invalid          = 1'b0;
    stall            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A store wins over a simultaneous load; the load is dropped.
        if (cpu_write) begin
          stall   = 1'b1;
          wdata_d = cpu_wdata;
          state_d = ST_WR_MEM;
          if (hit) begin
            if (UpdateOnHit) cache_word_write = 1'b1;
            else             invalid          = 1'b1;
          end
        end else if (cpu_read) begin
          if (hit) begin
            cache_read = 1'b1;
            hit_cnt_d  = hit_cnt_q + CNT_W'(1);
          end else begin
            stall      = 1'b1;
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
            off_d      = word_offset;
            state_d    = ST_REFILL;
          end
        end
      end

      ST_REFILL: begin
        mem_read = 1'b1;
        stall    = ~mem_ready;
        if (mem_ready) begin
          cache_write = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_WR_MEM: begin
        mem_write = 1'b1;
        stall     = ~mem_ready;
        if (mem_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      off_q      <= '0;
      wdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // During a refill the load result comes straight from the memory block.
  assign data_out   = (state_q == ST_REFILL) ? refill_word : word_from_cache;
  assign mem_wdata  = wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule : cache_ctrl_fsm

// File: tb/tb_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_fsm
// Directed bench for cache_ctrl_fsm. Two instances share all inputs:
// u_inv uses the invalidate write-hit policy with 32-bit counters, u_upd uses
// the update policy with 4-bit counters so counter wrap can be observed.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time
// unit later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_cache_ctrl_fsm;

  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int OFF_W  = 2;

  logic                    clk;
  logic                    rst;
  logic                    cpu_read;
  logic                    cpu_write;
  logic [OFF_W-1:0]        word_offset;
  logic [DATA_W-1:0]       cpu_wdata;
  logic                    hit;
  logic [DATA_W-1:0]       word_from_cache;
  logic [DATA_W*WORDS-1:0] block_from_mem;
  logic                    mem_ready;

  logic              mem_read_i, mem_write_i, cache_read_i, cache_write_i;
  logic              cache_word_write_i, invalid_i, stall_i;
  logic [DATA_W-1:0] mem_wdata_i, data_out_i;
  logic [31:0]       hit_count_i, miss_count_i;

  logic              mem_read_u, mem_write_u, cache_read_u, cache_write_u;
  logic              cache_word_write_u, invalid_u, stall_u;
  logic [DATA_W-1:0] mem_wdata_u, data_out_u;
  logic [3:0]        hit_count_u, miss_count_u;

  int n_vec = 0;
  int n_err = 0;

  cache_ctrl_fsm #(
    .DATA_W (DATA_W), .WORDS (WORDS), .WR_HIT_UPDATE (1'b0), .CNT_W (32)
  ) u_inv (
    .clk (clk), .rst (rst), .cpu_read (cpu_read), .cpu_write (cpu_write),
    .word_offset (word_offset), .cpu_wdata (cpu_wdata), .hit (hit),
    .word_from_cache (word_from_cache), .block_from_mem (block_from_mem),
    .mem_ready (mem_ready), .mem_read (mem_read_i), .mem_write (mem_write_i),
    .mem_wdata (mem_wdata_i), .cache_read (cache_read_i),
    .cache_write (cache_write_i), .cache_word_write (cache_word_write_i),
    .invalid (invalid_i), .stall (stall_i), .data_out (data_out_i),
    .hit_count (hit_count_i), .miss_count (miss_count_i)
  );

  cache_ctrl_fsm #(
    .DATA_W (DATA_W), .WORDS (WORDS), .WR_HIT_UPDATE (1'b1), .CNT_W (4)
  ) u_upd (
    .clk (clk), .rst (rst), .cpu_read (cpu_read), .cpu_write (cpu_write),
    .word_offset (word_offset), .cpu_wdata (cpu_wdata), .hit (hit),
    .word_from_cache (word_from_cache), .block_from_mem (block_from_mem),
    .mem_ready (mem_ready), .mem_read (mem_read_u), .mem_write (mem_write_u),
    .mem_wdata (mem_wdata_u), .cache_read (cache_read_u),
    .cache_write (cache_write_u), .cache_word_write (cache_word_write_u),
    .invalid (invalid_u), .stall (stall_u), .data_out (data_out_u),
    .hit_count (hit_count_u), .miss_count (miss_count_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and move 1 unit past the edge before driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    hit       = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    word_offset     = '0;
    cpu_wdata       = '0;
    word_from_cache = '0;
    block_from_mem  = 128'h44444444_33333333_22222222_11111111;
    idle_inputs();
    tick();
    tick();
    #1;
    // ---------------- reset state ----------------
    check("rst_stall",     {63'd0, stall_i},     64'd0);
    check("rst_mem_read",  {63'd0, mem_read_i},  64'd0);
    check("rst_mem_write", {63'd0, mem_write_i}, 64'd0);
    check("rst_mem_wdata", {32'd0, mem_wdata_i}, 64'd0);
    check("rst_hit_cnt",   {32'd0, hit_count_i}, 64'd0);
    check("rst_miss_cnt",  {32'd0, miss_count_i},64'd0);
    rst = 1'b0;
    tick();

    // ---------------- read hit ----------------
    cpu_read = 1'b1; word_offset = 2'd2; hit = 1'b1;
    word_from_cache = 32'hDEADBEEF;
    #1;
    check("rh_data",       {32'd0, data_out_i},  64'hDEADBEEF);
    check("rh_cache_read", {63'd0, cache_read_i},64'd1);
    check("rh_stall",      {63'd0, stall_i},     64'd0);
    check("rh_cnt_before", {32'd0, hit_count_i}, 64'd0);
    tick();
    idle_inputs();
    #1;
    check("rh_cnt_after",  {32'd0, hit_count_i}, 64'd1);

    // ---------------- read miss, 3 wait cycles ----------------
    cpu_read = 1'b1; word_offset = 2'd3; hit = 1'b0;
    word_from_cache = 32'h0BADF00D;
    #1;
    check("rm_accept_stall", {63'd0, stall_i},    64'd1);
    check("rm_accept_mrd",   {63'd0, mem_read_i}, 64'd0);
    tick();
    // The offset input moves away; the latched offset must still select word 3.
    word_offset = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check("rm_wait_stall", {63'd0, stall_i},       64'd1);
      check("rm_wait_mrd",   {63'd0, mem_read_i},    64'd1);
      check("rm_wait_cwr",   {63'd0, cache_write_i}, 64'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("rm_ready_data",  {32'd0, data_out_i},    64'h44444444);
    check("rm_ready_cwr",   {63'd0, cache_write_i}, 64'd1);
    check("rm_ready_stall", {63'd0, stall_i},       64'd0);
    check("rm_miss_cnt",    {32'd0, miss_count_i},  64'd1);
    check("rm_mrd_excl",    {63'd0, mem_write_i},   64'd0);
    tick();
    idle_inputs();
    #1;
    check("rm_done_mrd",   {63'd0, mem_read_i},  64'd0);
    check("rm_done_stall", {63'd0, stall_i},     64'd0);

    // ---------------- write hit, both policies ----------------
    cpu_write = 1'b1; hit = 1'b1; cpu_wdata = 32'h0000CAFE;
    #1;
    check("wh_inv_invalid", {63'd0, invalid_i},          64'd1);
    check("wh_inv_cww",     {63'd0, cache_word_write_i}, 64'd0);
    check("wh_upd_cww",     {63'd0, cache_word_write_u}, 64'd1);
    check("wh_upd_invalid", {63'd0, invalid_u},          64'd0);
    check("wh_stall",       {63'd0, stall_i},            64'd1);
    check("wh_no_cread",    {63'd0, cache_read_i},       64'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      check("wh_wait_mwr_i",   {63'd0, mem_write_i},        64'd1);
      check("wh_wait_mwr_u",   {63'd0, mem_write_u},        64'd1);
      check("wh_wait_stall",   {63'd0, stall_u},            64'd1);
      check("wh_wdata_i",      {32'd0, mem_wdata_i},        64'h0000CAFE);
      check("wh_wdata_u",      {32'd0, mem_wdata_u},        64'h0000CAFE);
      check("wh_wait_no_inv",  {63'd0, invalid_i},          64'd0);
      check("wh_wait_no_cww",  {63'd0, cache_word_write_u}, 64'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("wh_ready_stall", {63'd0, stall_i},     64'd0);
    check("wh_ready_mwr",   {63'd0, mem_write_i}, 64'd1);
    tick();
    idle_inputs();
    #1;
    check("wh_done_mwr",   {63'd0, mem_write_i}, 64'd0);
    check("wh_hit_cnt",    {32'd0, hit_count_i}, 64'd1);

    // ---------------- simultaneous read+write, miss ----------------
    cpu_read = 1'b1; cpu_write = 1'b1; hit = 1'b0; cpu_wdata = 32'h12345678;
    #1;
    check("rw_stall",      {63'd0, stall_i},      64'd1);
    check("rw_no_cread",   {63'd0, cache_read_i}, 64'd0);
    tick();
    #1;
    check("rw_mwr",        {63'd0, mem_write_i},  64'd1);
    check("rw_no_mrd",     {63'd0, mem_read_i},   64'd0);
    check("rw_miss_cnt",   {32'd0, miss_count_i}, 64'd1);
    check("rw_wdata",      {32'd0, mem_wdata_i},  64'h12345678);
    mem_ready = 1'b1;
    #1;
    check("rw_ready_stall", {63'd0, stall_i},     64'd0);
    tick();
    idle_inputs();

    // ---------------- idle ignores mem_ready ----------------
    mem_ready = 1'b1;
    #1;
    check("idle_stall", {63'd0, stall_i},       64'd0);
    check("idle_cwr",   {63'd0, cache_write_i}, 64'd0);
    tick();
    #1;
    check("idle_mwr",   {63'd0, mem_write_i},   64'd0);
    check("idle_mrd",   {63'd0, mem_read_i},    64'd0);
    mem_ready = 1'b0;

    // ---------------- reset mid-refill ----------------
    cpu_read = 1'b1; hit = 1'b0; word_offset = 2'd1;
    tick();
    #1;
    check("rr_refill_mrd", {63'd0, mem_read_i}, 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cpu_read = 1'b0;
    #1;
    check("rr_mrd",      {63'd0, mem_read_i},   64'd0);
    check("rr_stall",    {63'd0, stall_i},      64'd0);
    check("rr_hit_cnt",  {32'd0, hit_count_i},  64'd0);
    check("rr_miss_cnt", {32'd0, miss_count_i}, 64'd0);
    check("rr_wdata",    {32'd0, mem_wdata_i},  64'd0);
    mem_ready = 1'b1;
    #1;
    check("rr_late_cwr",   {63'd0, cache_write_i}, 64'd0);
    tick();
    #1;
    check("rr_late_mrd",   {63'd0, mem_read_i},    64'd0);
    mem_ready = 1'b0;

    // ---------------- counter wrap (4-bit counters in u_upd) ----------------
    cpu_read = 1'b1; hit = 1'b1; word_offset = 2'd0;
    for (int i = 0; i < 17; i++) tick();
    idle_inputs();
    #1;
    check("wrap_hit_cnt_32", {32'd0, hit_count_i}, 64'd17);
    check("wrap_hit_cnt_4",  {60'd0, hit_count_u}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cache_ctrl_fsm
